evt2_byte_packer: RTL and testbench

EVT2_BYTE_PACKER -- requirements
Module: evt2_byte_packer

---
 rtl/evt2_byte_packer.sv | 167 ++++++++++++++++
 tb/tb_evt2_byte_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/evt2_byte_packer.sv
// Packs UART bytes into 32-bit little-endian EVT2 words behind a 2-entry output FIFO,
// with an idle timeout that discards stale partial words and saturating drop/resync statistics.
module evt2_byte_packer #(
  parameter int TIMEOUT_CYCLES = 12000,
  parameter int STAT_BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 clear_stats,
  output logic [31:0]          evt_word,
  output logic                 evt_word_valid,
  input  logic                 evt_word_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic [STAT_BITS-1:0] words_dropped,
  output logic [STAT_BITS-1:0] resync_count
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};

  logic [1:0]           byte_idx_r, byte_idx_nxt_s;
  logic [23:0]          partial_r;
  logic [IDLE_W-1:0]    idle_cnt_r, idle_cnt_nxt_s;
  logic                 busy_r;
  logic [31:0]          head_word_r, head_word_nxt_s;
  logic [31:0]          tail_word_r, tail_word_nxt_s;
  logic                 head_valid_r, head_valid_nxt_s;
  logic                 tail_valid_r, tail_valid_nxt_s;
  logic                 overflow_r;
  logic [STAT_BITS-1:0] dropped_r, resync_r;

  logic        word_done_s, pop_s, full_s, push_s, drop_s, timeout_s;
  logic [31:0] new_word_s;

  assign word_done_s = byte_valid && (byte_idx_r == 2'd3);
  assign new_word_s  = {byte_in, partial_r};
  assign pop_s       = head_valid_r && evt_word_ready;
  assign full_s      = head_valid_r && tail_valid_r;
  // A pop in the same cycle frees the slot the completing word needs.
  assign push_s      = word_done_s && (!full_s || pop_s);
  assign drop_s      = word_done_s && full_s && !pop_s;
  assign timeout_s   = busy_r && !byte_valid && (idle_cnt_r == IDLE_LAST);

  // Byte index and idle counter next state; an arriving byte beats the timeout.
  always_comb begin
    byte_idx_nxt_s = byte_idx_r;
    idle_cnt_nxt_s = idle_cnt_r;
    if (byte_valid) begin
      byte_idx_nxt_s = byte_idx_r + 2'd1;
      idle_cnt_nxt_s = {IDLE_W{1'b0}};
    end else if (timeout_s) begin
      byte_idx_nxt_s = 2'd0;
      idle_cnt_nxt_s = {IDLE_W{1'b0}};
    end else if (busy_r) begin
      idle_cnt_nxt_s = idle_cnt_r + {{(IDLE_W-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_nxt_s = {IDLE_W{1'b0}};
    end
  end

  // Two-entry FIFO next state; the head register drives the output directly.
  always_comb begin
    head_word_nxt_s  = head_word_r;
    tail_word_nxt_s  = tail_word_r;
    head_valid_nxt_s = head_valid_r;
    tail_valid_nxt_s = tail_valid_r;
    case ({pop_s, push_s})
      2'b11: begin
        if (tail_valid_r) begin
          head_word_nxt_s = tail_word_r;
          tail_word_nxt_s = new_word_s;
        end else begin
          head_word_nxt_s = new_word_s;
        end
      end
      2'b10: begin
        head_word_nxt_s  = tail_word_r;
        head_valid_nxt_s = tail_valid_r;
        tail_valid_nxt_s = 1'b0;
      end
      2'b01: begin
        if (!head_valid_r) begin
          head_word_nxt_s  = new_word_s;
          head_valid_nxt_s = 1'b1;
        end else begin
          tail_word_nxt_s  = new_word_s;
          tail_valid_nxt_s = 1'b1;
        end
      end
      default: begin
        head_valid_nxt_s = head_valid_r;
      end
    endcase
  end

  // Assembly state: byte index, partial bytes, idle counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_r <= 2'd0;
      partial_r  <= 24'd0;
      idle_cnt_r <= {IDLE_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      byte_idx_r <= byte_idx_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      busy_r     <= (byte_idx_nxt_s != 2'd0);
      if (byte_valid) begin
        case (byte_idx_r)
          2'd0:    partial_r[7:0]   <= byte_in;
          2'd1:    partial_r[15:8]  <= byte_in;
          2'd2:    partial_r[23:16] <= byte_in;
          default: partial_r        <= partial_r;
        endcase
      end
    end
  end

  // FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_word_r  <= 32'd0;
      tail_word_r  <= 32'd0;
      head_valid_r <= 1'b0;
      tail_valid_r <= 1'b0;
    end else begin
      head_word_r  <= head_word_nxt_s;
      tail_word_r  <= tail_word_nxt_s;
      head_valid_r <= head_valid_nxt_s;
      tail_valid_r <= tail_valid_nxt_s;
    end
  end

  // Statistics; a clear request overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      dropped_r  <= {STAT_BITS{1'b0}};
      resync_r   <= {STAT_BITS{1'b0}};
    end else if (clear_stats) begin
      overflow_r <= 1'b0;
      dropped_r  <= {STAT_BITS{1'b0}};
      resync_r   <= {STAT_BITS{1'b0}};
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (dropped_r != STAT_MAX) begin
          dropped_r <= dropped_r + {{(STAT_BITS-1){1'b0}}, 1'b1};
        end
      end
      if (timeout_s && (resync_r != STAT_MAX)) begin
        resync_r <= resync_r + {{(STAT_BITS-1){1'b0}}, 1'b1};
      end
    end
  end

  assign evt_word       = head_word_r;
  assign evt_word_valid = head_valid_r;
  assign busy           = busy_r;
  assign overflow       = overflow_r;
  assign words_dropped  = dropped_r;
  assign resync_count   = resync_r;

endmodule

// File: tb/tb_evt2_byte_packer.sv
// Randomized and directed bench for evt2_byte_packer: a queue-based reference model feeds a
// scoreboard that a negedge monitor drains whenever the DUT hands off a word.
module tb_evt2_byte_packer;

  localparam int TIMEOUT = 16;
  localparam int SB      = 4;
  localparam logic [SB-1:0] SMAX = 4'hF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid = 1'b0;
  logic          clear_stats = 1'b0;
  logic [31:0]   evt_word;
  logic          evt_word_valid;
  logic          evt_word_ready = 1'b0;
  logic          busy;
  logic          overflow;
  logic [SB-1:0] words_dropped;
  logic [SB-1:0] resync_count;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]    m_part[$];
  logic [31:0]   m_fifo[$];
  logic [31:0]   exp_q[$];
  int            m_gap = 0;
  bit            m_pop;
  bit            m_ovf = 1'b0;
  logic [SB-1:0] m_drop = '0;
  logic [SB-1:0] m_res = '0;
  logic [31:0]   m_w;

  evt2_byte_packer #(.TIMEOUT_CYCLES(TIMEOUT), .STAT_BITS(SB)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .clear_stats(clear_stats), .evt_word(evt_word), .evt_word_valid(evt_word_valid),
    .evt_word_ready(evt_word_ready), .busy(busy), .overflow(overflow),
    .words_dropped(words_dropped), .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      m_w = w >> (8 * i);
      send_byte(m_w[7:0]);
    end
  endtask

  // Behavioural model: a word is the last four accepted bytes, kept if the 2-deep queue has room.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_part.delete(); m_fifo.delete(); exp_q.delete();
      m_gap = 0; m_ovf = 1'b0; m_drop = '0; m_res = '0;
    end else begin
      m_pop = evt_word_ready && (m_fifo.size() > 0);
      if (m_pop) void'(m_fifo.pop_front());
      if (byte_valid) begin
        m_part.push_back(byte_in);
        m_gap = 0;
        if (m_part.size() == 4) begin
          m_w = {m_part[3], m_part[2], m_part[1], m_part[0]};
          m_part.delete();
          if (m_fifo.size() < 2) begin
            m_fifo.push_back(m_w);
            exp_q.push_back(m_w);
          end else begin
            m_ovf = 1'b1;
            if (m_drop != SMAX) m_drop = m_drop + 4'd1;
          end
        end
      end else if (m_part.size() != 0) begin
        m_gap++;
        if (m_gap == TIMEOUT) begin
          m_part.delete();
          m_gap = 0;
          if (m_res != SMAX) m_res = m_res + 4'd1;
        end
      end
      if (clear_stats) begin
        m_ovf = 1'b0; m_drop = '0; m_res = '0;
      end
    end
  end

  // Monitor: compare status every cycle and words against the scoreboard on handoff.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("valid", 32'(evt_word_valid), 32'(m_fifo.size() > 0));
      check("busy", 32'(busy), 32'(m_part.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("words_dropped", 32'(words_dropped), 32'(m_drop));
      check("resync_count", 32'(resync_count), 32'(m_res));
      if (evt_word_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL word actual=%h expected=none (scoreboard empty)", evt_word);
        end else begin
          check("word", evt_word, exp_q[0]);
          if (evt_word_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int p, q;
    repeat (3) tick();
    check("rst_valid", 32'(evt_word_valid), 32'd0);
    check("rst_word", evt_word, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stats", {23'd0, overflow, words_dropped, resync_count}, 32'd0);
    rst_n = 1'b1;

    // Basic word, byte honoured in first cycle after release
    evt_word_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("basic_valid", 32'(evt_word_valid), 32'd1);
    check("basic_word", evt_word, 32'h44332211);
    tick();
    check("basic_valid_1cyc", 32'(evt_word_valid), 32'd0);

    // Overflow with ready low, then drain in order and clear stats
    evt_word_ready = 1'b0;
    send_word(32'hA1A2A3A4); send_word(32'hB1B2B3B4); send_word(32'hC1C2C3C4);
    check("ovf_dropped", 32'(words_dropped), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    evt_word_ready = 1'b1;
    repeat (4) tick();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    check("clear_stats", {31'd0, overflow} | 32'(words_dropped), 32'd0);

    // Timeout discards a partial word
    send_byte(8'h01); send_byte(8'h02);
    repeat (20) tick();
    check("timeout_resync", 32'(resync_count), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    send_word(32'h0D0C0B0A);
    repeat (2) tick();

    // Byte exactly at the timeout cycle wins
    send_byte(8'h55); send_byte(8'h66);
    repeat (TIMEOUT - 1) tick();
    send_byte(8'h77);
    check("edge_no_resync", 32'(resync_count), 32'd1);
    check("edge_busy", 32'(busy), 32'd1);
    send_byte(8'h88);
    repeat (2) tick();

    // Full FIFO, 4th byte coincides with a pop
    evt_word_ready = 1'b0;
    send_word(32'h11111111); send_word(32'h22222222);
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    evt_word_ready = 1'b1; byte_valid = 1'b1; byte_in = 8'h34;
    tick();
    byte_valid = 1'b0; evt_word_ready = 1'b0;
    check("coincide_no_drop", 32'(words_dropped), 32'd0);
    tick();
    evt_word_ready = 1'b1;
    repeat (4) tick();

    // Drop counter saturates
    evt_word_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_word($urandom);
    check("drop_saturate", 32'(words_dropped), 32'(SMAX));
    evt_word_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-operation with one word buffered and a partial word in progress
    evt_word_ready = 1'b0;
    send_word(32'hDEADBEEF);
    send_byte(8'hAA); send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(evt_word_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stats", {23'd0, overflow, words_dropped, resync_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    send_word(32'h87654321);
    check("post_rst_valid", 32'(evt_word_valid), 32'd1);
    check("post_rst_word", evt_word, 32'h87654321);
    evt_word_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic
    p = 50; q = 70;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(3, 0))
          0: p = 90; 1: p = 50; 2: p = 10; default: p = 3;
        endcase
        case ($urandom_range(3, 0))
          0: q = 100; 1: q = 70; 2: q = 30; default: q = 0;
        endcase
      end
      byte_valid     = ($urandom_range(99, 0) < p);
      byte_in        = 8'($urandom);
      evt_word_ready = ($urandom_range(99, 0) < q);
      clear_stats    = ($urandom_range(63, 0) == 0);
      tick();
    end
    byte_valid = 1'b0; clear_stats = 1'b0; evt_word_ready = 1'b1;
    repeat (10) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
